// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Define ALU_SHARE_ARBITER_STATS_EN to add saturating per-requester grant counters.
module alu_share_arbiter #(
    parameter int DATA_W  = 4,
    parameter int SEL_W   = 2,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_res,
`ifdef ALU_SHARE_ARBITER_STATS_EN
    input  logic              stats_clr,
    output logic [7:0]        gnt0_cnt,
    output logic [7:0]        gnt1_cnt,
`endif
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

    logic [1:0] state;
    logic       owner;
    logic       last_grant;
    logic [3:0] cnt;
    logic       win0;
    logic       win1;
    logic       hs0;
    logic       hs1;

    // On contention the requester that did not win last time takes the grant.
    always_comb begin
        win0 = req0_valid & (~req1_valid | last_grant);
        win1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign req0_ready  = (state == IDLE) & win0;
    assign req1_ready  = (state == IDLE) & win1;
    assign hs0         = req0_valid & req0_ready;
    assign hs1         = req1_valid & req1_ready;
    assign busy        = (state != IDLE);
    assign resp0_valid = (state == RESP) & ~owner;
    assign resp1_valid = (state == RESP) & owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            resp0_data <= '0;
            resp1_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs0 | hs1) begin
                        owner      <= hs1;
                        last_grant <= hs1;
                        alu_a      <= hs1 ? req1_a   : req0_a;
                        alu_b      <= hs1 ? req1_b   : req0_b;
                        alu_sel    <= hs1 ? req1_sel : req0_sel;
                        cnt        <= '0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAT_LAST) begin
                        if (owner) resp1_data <= alu_res;
                        else       resp0_data <= alu_res;
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else if (stats_clr) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (hs0 && gnt0_cnt != '1) gnt0_cnt <= gnt0_cnt + 8'd1;
            if (hs1 && gnt1_cnt != '1) gnt1_cnt <= gnt1_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter: ALU_LAT=1 and ALU_LAT=3 instances share
// the stimulus and are checked against a transaction-level timing/data model.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0] s0 = '0, s1 = '0;
    logic       clr = 1'b0;

    logic       rdy0 [2];
    logic       rdy1 [2];
    logic       rv0  [2];
    logic       rv1  [2];
    logic       bsy  [2];
    logic [3:0] rd0  [2];
    logic [3:0] rd1  [2];
    logic [3:0] aa   [2];
    logic [3:0] ab   [2];
    logic [3:0] ares [2];
    logic [1:0] asel [2];
    logic [7:0] g0c  [2];
    logic [7:0] g1c  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state, one set per instance
    int         m_free [2];
    int         m_resp [2];
    logic       m_lastg[2];
    logic       m_owner[2];
    logic [3:0] m_pend [2];
    logic [3:0] m_d0   [2];
    logic [3:0] m_d1   [2];
    logic [3:0] m_a    [2];
    logic [3:0] m_b    [2];
    logic [1:0] m_s    [2];
    int         m_g0   [2];
    int         m_g1   [2];
    logic       hs0    [2];
    logic       hs1    [2];

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a - b;
        endcase
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign ares[g] = alu_f(aa[g], ab[g], asel[g]);
        alu_share_arbiter #(.DATA_W(4), .SEL_W(2), .ALU_LAT((g == 0) ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_valid (v0),
            .req0_ready (rdy0[g]),
            .req0_a     (a0),
            .req0_b     (b0),
            .req0_sel   (s0),
            .resp0_valid(rv0[g]),
            .resp0_data (rd0[g]),
            .req1_valid (v1),
            .req1_ready (rdy1[g]),
            .req1_a     (a1),
            .req1_b     (b1),
            .req1_sel   (s1),
            .resp1_valid(rv1[g]),
            .resp1_data (rd1[g]),
            .alu_a      (aa[g]),
            .alu_b      (ab[g]),
            .alu_sel    (asel[g]),
            .alu_res    (ares[g]),
`ifdef ALU_SHARE_ARBITER_STATS_EN
            .stats_clr  (clr),
            .gnt0_cnt   (g0c[g]),
            .gnt1_cnt   (g1c[g]),
`endif
            .busy       (bsy[g])
        );
`ifndef ALU_SHARE_ARBITER_STATS_EN
        assign g0c[g] = '0;
        assign g1c[g] = '0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_free[d]  = 0;
            m_resp[d]  = -1;
            m_lastg[d] = 1'b1;
            m_owner[d] = 1'b0;
            m_pend[d]  = '0;
            m_d0[d]    = '0;
            m_d1[d]    = '0;
            m_a[d]     = '0;
            m_b[d]     = '0;
            m_s[d]     = '0;
            m_g0[d]    = 0;
            m_g1[d]    = 0;
        end
    endtask

    // One clock cycle: compare at negedge, advance the model at posedge.
    task automatic step();
        logic  idle;
        string p;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            p = $sformatf("L%0d", lat_of(d));
            if (cyc == m_resp[d]) begin
                if (m_owner[d]) m_d1[d] = m_pend[d];
                else            m_d0[d] = m_pend[d];
            end
            idle   = (cyc >= m_free[d]);
            hs0[d] = idle && v0 && (!v1 || m_lastg[d]);
            hs1[d] = idle && v1 && (!v0 || !m_lastg[d]);
            check({p, " ready0"}, 32'(rdy0[d]), 32'(hs0[d]));
            check({p, " ready1"}, 32'(rdy1[d]), 32'(hs1[d]));
            check({p, " busy"},   32'(bsy[d]),  32'(!idle));
            check({p, " resp0_valid"}, 32'(rv0[d]), 32'(cyc == m_resp[d] && !m_owner[d]));
            check({p, " resp1_valid"}, 32'(rv1[d]), 32'(cyc == m_resp[d] && m_owner[d]));
            check({p, " resp0_data"}, 32'(rd0[d]), 32'(m_d0[d]));
            check({p, " resp1_data"}, 32'(rd1[d]), 32'(m_d1[d]));
            check({p, " alu_a"},   32'(aa[d]),   32'(m_a[d]));
            check({p, " alu_b"},   32'(ab[d]),   32'(m_b[d]));
            check({p, " alu_sel"}, 32'(asel[d]), 32'(m_s[d]));
`ifdef ALU_SHARE_ARBITER_STATS_EN
            check({p, " gnt0_cnt"}, 32'(g0c[d]), 32'(m_g0[d]));
            check({p, " gnt1_cnt"}, 32'(g1c[d]), 32'(m_g1[d]));
`endif
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (hs0[d] || hs1[d]) begin
                m_owner[d] = hs1[d];
                m_lastg[d] = hs1[d];
                m_a[d]     = hs1[d] ? a1 : a0;
                m_b[d]     = hs1[d] ? b1 : b0;
                m_s[d]     = hs1[d] ? s1 : s0;
                m_pend[d]  = alu_f(m_a[d], m_b[d], m_s[d]);
                m_resp[d]  = cyc + lat_of(d) + 1;
                m_free[d]  = cyc + lat_of(d) + 2;
            end
            if (clr) begin
                m_g0[d] = 0;
                m_g1[d] = 0;
            end else begin
                if (hs0[d] && m_g0[d] < 255) m_g0[d]++;
                if (hs1[d] && m_g1[d] < 255) m_g1[d]++;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Quiet idle after reset
        repeat (10) step();

        // Single requester-0 subtraction: 12 - 13 = 15 (mod 16)
        v0 = 1'b1; a0 = 4'b1100; b0 = 4'b1101; s0 = 2'b11;
        step();
        v0 = 1'b0;
        repeat (5) step();
        check("L1 sub result", 32'(rd0[0]), 32'hF);
        check("L3 sub result", 32'(rd0[1]), 32'hF);

        // Contention: both hold valid, grants must alternate
        v0 = 1'b1; a0 = 4'd3; b0 = 4'd4; s0 = 2'd0;
        v1 = 1'b1; a1 = 4'd9; b1 = 4'd9; s1 = 2'd0;
        repeat (32) step();
        check("L3 contention r0", 32'(rd0[1]), 32'h7);
        check("L3 contention r1", 32'(rd1[1]), 32'h2);
        v0 = 1'b0; v1 = 1'b0;
        repeat (6) step();

        // Randomized traffic
        for (int unsigned i = 0; i < 2000; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            a0 = 4'($urandom); b0 = 4'($urandom); s0 = 2'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); s1 = 2'($urandom);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (6) step();

        // Async reset while both instances are in EXEC
        v1 = 1'b1; a1 = 4'd5; b1 = 4'd6; s1 = 2'd2;
        step();
        v1 = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst busy",  32'(bsy[d]), 32'h0);
            check("rst alu_a", 32'(aa[d]),  32'h0);
            check("rst alu_sel", 32'(asel[d]), 32'h0);
            check("rst resp1_valid", 32'(rv1[d]), 32'h0);
            check("rst resp1_data",  32'(rd1[d]), 32'h0);
        end
        rst = 1'b0;
        model_reset();
        repeat (5) step();
        v0 = 1'b1; v1 = 1'b1;
        step();
        v0 = 1'b0; v1 = 1'b0;
        repeat (6) step();

`ifdef ALU_SHARE_ARBITER_STATS_EN
        clr = 1'b1;
        step();
        clr = 1'b0;
        v1 = 1'b1;
        repeat (1600) step();
        v1 = 1'b0;
        repeat (6) step();
        for (int d = 0; d < 2; d++) begin
            check("gnt1 saturated", 32'(g1c[d]), 32'd255);
            check("gnt0 zero",      32'(g0c[d]), 32'd0);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 4-bit combinational ALU (operand A, operand B, 2-bit op select, 4-bit result) between two requesters. Uses a valid/ready request handshake and round-robin arbitration. The block registers the winning operands onto the ALU inputs, waits ALU_LAT cycles and captures the result. It then returns the result to the winner as a one-cycle response pulse. It sits between the switch/host front-ends and the ALU core in the board top level.

Parameters:
DATA_W, 4, operand/result width
SEL_W, 2, ALU op-select width
ALU_LAT, 1, cycles the ALU inputs are held before the result is sampled (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  DATA_W  requester 0 operand A
req0_b  in  DATA_W  requester 0 operand B
req0_sel  in  SEL_W  requester 0 op select
resp0_valid  out  1  one-cycle pulse, result for requester 0
resp0_data  out  DATA_W  result for requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as requester 0, for requester 1
resp1_valid, resp1_data  same as requester 0, for requester 1
alu_a  out  DATA_W  registered operand A to ALU
alu_b  out  DATA_W  registered operand B to ALU
alu_sel  out  SEL_W  registered op select to ALU
alu_res  in  DATA_W  ALU result
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous and active-high.
- Reset values: state=IDLE, alu_a/alu_b/alu_sel=0, resp*_valid=0, resp*_data=0, busy=0, last_grant=1 (so requester 0 wins first), latency counter=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection: if only one reqN_valid is high, that requester wins. If both are high, the requester other than last_grant wins.
  - reqN_ready is combinational: high only for the winner, and only in IDLE. It may never be high for both requesters.
  - Handshake is valid&ready. On handshake, latch a/b/sel into alu_a/alu_b/alu_sel, record the owner, set last_grant=owner, clear the counter, and go to EXEC.
- EXEC:
  - ALU inputs are held stable.
  - The counter increments each cycle. In the cycle the counter equals ALU_LAT-1, alu_res is sampled into resp<owner>_data and the FSM goes to RESP.
- RESP:
  - resp<owner>_valid=1 for exactly one cycle; the other resp_valid stays 0.
  - No response backpressure; the requester must accept the pulse.
  - Next state is IDLE. No new grant is issued in RESP.
- Timing: handshake in cycle T -> ALU inputs valid from T+1 -> resp pulse in T+ALU_LAT+1 -> next handshake no earlier than T+ALU_LAT+2.
- Data hold: respN_data holds its last value until overwritten by the next result for that requester. The non-owner's data register is untouched.
- alu_a/alu_b/alu_sel retain their last operation values in IDLE.
- Requester inputs are ignored outside handshake cycles. A requester may drop valid before being granted without effect.
- Width rules: no arithmetic on data. The counter is 4 bits and compared as unsigned.
- Reset mid-operation (EXEC or RESP): immediate return to IDLE and all reset values. The in-flight op is dropped with no response pulse. last_grant returns to 1.
- Simultaneous requests, back-to-back: grants strictly alternate 0,1,0,1 while both requesters hold valid high.

Optional Feature:
Macro ALU_SHARE_ARBITER_STATS_EN.
- Defined: adds outputs gnt0_cnt and gnt1_cnt, each 8 bits.
  - Each counts handshakes for its requester and saturates at 255.
  - Both reset to 0.
  - Adds input stats_clr (1 bit): synchronous clear of both counters. If clear and increment coincide in the same cycle, clear wins.
- Undefined: these ports and the counter logic do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: after rst deassert, both ready=0, resp_valid=0, busy=0, alu_a/b/sel=0. Holds for 10 cycles with no valid.
- Single op, requester 0, ALU_LAT=1: bench ALU model with sel 2'b11 = a-b mod 16. Inputs a=4'b1100, b=4'b1101, sel=2'b11, handshake at T -> resp0_valid=1 and resp0_data=4'b1111 at T+2. resp1_valid stays 0.
- Contention: both requesters hold valid continuously, req0 ADD 3+4, req1 ADD 9+9 -> first resp0_data=7, then resp1_data=4'b0010. Grants alternate over 6 ops. ready is never high for both.
- ALU_LAT=3: handshake at T -> alu inputs stable T+1..T+3, resp at T+4, busy high T+1..T+4.
- Async reset during EXEC: rst pulsed mid-cycle -> outputs reset immediately, no resp pulse, next contended grant goes to requester 0.
- ALU_SHARE_ARBITER_STATS_EN: 300 requester-1 ops -> gnt1_cnt=255 and gnt0_cnt=0. stats_clr -> both counters 0 the next cycle.
